// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
//   mtrans_t     : 32-bit memory data word
//   addr_t       : 32-bit byte address
//   mreq_t       : request payload {a, we, be, d}
//   owner_e      : which requester owns the outstanding transaction
//   arb_state_e  : arbiter FSM state
package mem_arbiter_pkg;

  typedef logic [31:0] mtrans_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    addr_t      a;
    logic       we;
    logic [3:0] be;
    mtrans_t    d;
  } mreq_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch (IF) and load/store (LS) requests onto one memory port,
// with at most one transaction outstanding. LS wins contested arbitration unless IF has
// lost STARVE_LIMIT contested rounds in a row. A stalled grant is locked until accepted.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   i_if_req_* / o_if_req_ready   : fetch request (valid/ready/data)
//   o_if_resp_* / i_if_resp_ready : fetch response
//   i_ls_req_* / o_ls_req_ready   : load/store request
//   o_ls_resp_* / i_ls_resp_ready : load/store response
//   o_mem_req_* / i_mem_req_ready : shared memory request
//   i_mem_resp_* / o_mem_resp_ready : shared memory response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,

  input  logic    i_if_req_valid,
  output logic    o_if_req_ready,
  input  mreq_t   i_if_req_data,
  output logic    o_if_resp_valid,
  input  logic    i_if_resp_ready,
  output mtrans_t o_if_resp_data,

  input  logic    i_ls_req_valid,
  output logic    o_ls_req_ready,
  input  mreq_t   i_ls_req_data,
  output logic    o_ls_resp_valid,
  input  logic    i_ls_resp_ready,
  output mtrans_t o_ls_resp_data,

  output logic    o_mem_req_valid,
  input  logic    i_mem_req_ready,
  output mreq_t   o_mem_req_data,
  input  logic    i_mem_resp_valid,
  output logic    o_mem_resp_ready,
  input  mtrans_t i_mem_resp_data
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] LimitCnt = CntW'(STARVE_LIMIT);

  arb_state_e      r_state,      w_state_nxt;
  owner_e          r_owner,      w_owner_nxt;
  logic            r_lock,       w_lock_nxt;
  owner_e          r_lock_owner, w_lock_owner_nxt;
  logic [CntW-1:0] r_starve_cnt, w_starve_cnt_nxt;

  owner_e w_winner;
  logic   w_win_valid;
  logic   w_idle;
  logic   w_busy;
  logic   w_req_fire;
  logic   w_resp_fire;

  // Outputs are gated by rst so everything reads 0 while reset is held.
  assign w_idle = rst && (r_state == ARB_IDLE);
  assign w_busy = rst && (r_state == ARB_BUSY);

  // Winner selection; a locked grant overrides fresh arbitration.
  always_comb begin
    w_winner = OWN_LS;
    if (r_lock) begin
      w_winner = r_lock_owner;
    end else if (i_if_req_valid && i_ls_req_valid) begin
      w_winner = (r_starve_cnt == LimitCnt) ? OWN_IF : OWN_LS;
    end else if (i_if_req_valid) begin
      w_winner = OWN_IF;
    end
  end

  assign w_win_valid = (w_winner == OWN_IF) ? i_if_req_valid : i_ls_req_valid;

  // Request side: inline grant mux.
  assign o_mem_req_valid = w_idle && w_win_valid;
  assign o_mem_req_data  = (w_winner == OWN_IF) ? i_if_req_data : i_ls_req_data;
  assign o_if_req_ready  = w_idle && (w_winner == OWN_IF) && i_mem_req_ready;
  assign o_ls_req_ready  = w_idle && (w_winner == OWN_LS) && i_mem_req_ready;
  assign w_req_fire      = o_mem_req_valid && i_mem_req_ready;

  // Response side: only the owner sees the memory response, and only while BUSY.
  assign o_if_resp_valid  = w_busy && (r_owner == OWN_IF) && i_mem_resp_valid;
  assign o_ls_resp_valid  = w_busy && (r_owner == OWN_LS) && i_mem_resp_valid;
  assign o_if_resp_data   = i_mem_resp_data;
  assign o_ls_resp_data   = i_mem_resp_data;
  assign o_mem_resp_ready = w_busy &&
                            ((r_owner == OWN_IF) ? i_if_resp_ready : i_ls_resp_ready);
  assign w_resp_fire      = o_mem_resp_ready && i_mem_resp_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_starve_cnt_nxt = r_starve_cnt;
    // Lock only while the winner is presenting and stalled; a dropped valid releases it.
    w_lock_nxt       = o_mem_req_valid && !i_mem_req_ready;
    w_lock_owner_nxt = w_lock_nxt ? w_winner : r_lock_owner;

    unique case (r_state)
      ARB_IDLE: begin
        if (w_req_fire) begin
          w_state_nxt = ARB_BUSY;
          w_owner_nxt = w_winner;
          if (w_winner == OWN_IF) begin
            w_starve_cnt_nxt = '0;
          end else if (i_if_req_valid && (r_starve_cnt != LimitCnt)) begin
            w_starve_cnt_nxt = r_starve_cnt + CntW'(1);
          end
        end
      end
      ARB_BUSY: begin
        if (w_resp_fire) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_IF;
      r_lock       <= 1'b0;
      r_lock_owner <= OWN_IF;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_lock       <= w_lock_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

endmodule
